// File: rtl/memsim_pkg.sv
// -----------------------------------------------------------------------------
// memsim_pkg
// Shared definitions for the stalling memory responder and its bench model:
//   - state_e           : responder FSM states (IDLE, WAIT)
//   - LFSR_POLY         : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   - LFSR_SEED_DEFAULT : default LFSR reset value (must be nonzero)
//   - stall_draw()      : maps 5 LFSR bits to a stall count in 0..max_stall
// -----------------------------------------------------------------------------
package memsim_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_POLY         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Stall count for one request: the low LFSR bits folded into 0..max_stall.
  function automatic logic [4:0] stall_draw(input logic [4:0] v,
                                            input int unsigned max_stall);
    logic [31:0] r;
    r = {27'd0, v} % (max_stall + 32'd1);
    return r[4:0];
  endfunction

endpackage

// File: rtl/memsim_lfsr16.sv
// -----------------------------------------------------------------------------
// memsim_lfsr16
// 16-bit right-shifting Galois LFSR (mask LFSR_POLY). Advances one step on each
// rising edge where `step` is high; reloads SEED on reset.
// Ports:
//   clk   in   clock
//   rstn  in   asynchronous active-low reset
//   step  in   advance the generator this cycle
//   value out  current generator state
// -----------------------------------------------------------------------------
module memsim_lfsr16
  import memsim_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] r_lfsr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lfsr <= SEED;
    end else if (step) begin
      r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_POLY) : (r_lfsr >> 1);
    end
  end

  assign value = r_lfsr;

endmodule

// File: rtl/memory_stall_responder.sv
// -----------------------------------------------------------------------------
// memory_stall_responder
// Word-addressed 32-bit RAM that answers each request after a pseudo-random
// stall of 0..MAX_STALL cycles, reported on `miss`.
// Build option: define MEMSIM_RANDOM_STALL_EN to enable the random stalls;
// without it every request commits in its first cycle and `miss` stays 0.
// Ports:
//   clk           in   clock
//   rstn          in   asynchronous active-low reset
//   addr[31:0]    in   byte address; addr[ADDR_W+1:2] selects the word
//   data_in[31:0] in   write data
//   write_enable  in   write request (wins when both enables are high)
//   read_enable   in   read request
//   data_out[31:0] out registered read data, held until the next read commit
//   miss          out  stall; requester holds its inputs while high
// -----------------------------------------------------------------------------
module memory_stall_responder
  import memsim_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter int          MAX_STALL = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] data_out,
  output logic        miss
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              w_req;
  logic              w_commit;
  logic              w_miss;
  logic              w_write;
  logic              w_read;
  logic [ADDR_W-1:0] w_word;
  logic              w_unused_addr;
  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_dout;

  assign w_req         = read_enable | write_enable;
  assign w_word        = addr[ADDR_W+1:2];
  assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

`ifdef MEMSIM_RANDOM_STALL_EN
  state_e      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [15:0] w_lfsr;
  logic [4:0]  w_draw;
  logic        w_step;

  // One draw per request: the generator moves only when a request starts.
  assign w_step = (r_state == IDLE) && w_req;

  memsim_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rstn  (rstn),
    .step  (w_step),
    .value (w_lfsr)
  );

  assign w_draw = stall_draw(w_lfsr[4:0], MAX_STALL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_miss      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_draw == 5'd0) begin
            w_commit = 1'b1;
          end else begin
            // The first stalled cycle is this one, so WAIT covers draw-1 more.
            w_miss      = 1'b1;
            w_cnt_nxt   = w_draw - 5'd1;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (r_cnt != 5'd0) begin
          w_miss    = 1'b1;
          w_cnt_nxt = r_cnt - 5'd1;
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
`else
  logic w_unused_cfg;

  assign w_commit     = w_req;
  assign w_miss       = 1'b0;
  assign w_unused_cfg = ^{MAX_STALL[0], LFSR_SEED[0]};
`endif

  // Reset gates the commit so a request held during reset never touches RAM.
  assign w_write = rstn & w_commit & write_enable;
  assign w_read  = rstn & w_commit & read_enable & ~write_enable;

  // NOTE: the RAM array has no reset; its contents are undefined until written,
  // which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[w_word] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dout <= '0;
    end else if (w_read) begin
      r_dout <= r_mem[w_word];
    end
  end

  assign data_out = r_dout;
  assign miss     = rstn & w_miss;

endmodule

// File: tb/tb_memory_stall_responder.sv
// -----------------------------------------------------------------------------
// tb_memory_stall_responder
// Scoreboard bench: each issued request pushes its predicted stall count and
// predicted data_out into a queue; a monitor on the falling edge counts miss
// cycles, pops at each commit and checks data_out one cycle later.
// Honours MEMSIM_RANDOM_STALL_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_memory_stall_responder;
  import memsim_pkg::*;

  localparam int          ADDR_W    = 14;
  localparam int          MAX_STALL = 16;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [31:0] data_out;
  logic        miss;

  always #5 clk = ~clk;

  memory_stall_responder #(
    .ADDR_W    (ADDR_W),
    .MAX_STALL (MAX_STALL),
    .LFSR_SEED (SEED)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .addr         (addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_out     (data_out),
    .miss         (miss)
  );

  typedef struct packed {
    logic [4:0]  stalls;
    logic [31:0] dout;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_lfsr = SEED;
  logic [31:0] m_dout = '0;
  logic [31:0] m_mem [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] peek_draw();
`ifdef MEMSIM_RANDOM_STALL_EN
    return stall_draw(m_lfsr[4:0], MAX_STALL);
`else
    return 5'd0;
`endif
  endfunction

  function automatic void model_step();
`ifdef MEMSIM_RANDOM_STALL_EN
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`endif
  endfunction

  // ---------------- monitor ----------------
  logic        chk_pending = 1'b0;
  logic [31:0] chk_dout = '0;
  int          stall_cnt = 0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (chk_pending) begin
      check("data_out", data_out, chk_dout);
      chk_pending = 1'b0;
    end
    if (!rstn) begin
      check("miss_in_reset", 32'(miss), 32'd0);
      stall_cnt = 0;
    end else if (!(read_enable | write_enable)) begin
      check("miss_when_idle", 32'(miss), 32'd0);
      stall_cnt = 0;
    end else if (miss) begin
      stall_cnt++;
    end else begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_commit: got a commit, expected none (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("stall_count", 32'(stall_cnt), 32'(mon_e.stalls));
        chk_pending = 1'b1;
        chk_dout    = mon_e.dout;
      end
      stall_cnt = 0;
    end
  end

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic do_req(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    exp_t x;
    int   w;
    int   c;
    bit   done;
    w = int'(a[ADDR_W+1:2]);
    x.stalls = peek_draw();
    model_step();
    if (we) m_mem[w] = d;
    else if (re) m_dout = m_mem[w];
    x.dout = m_dout;
    sb.push_back(x);
    write_enable = we;
    read_enable  = re;
    addr         = a;
    data_in      = d;
    done = 1'b0;
    c    = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      if (!miss) done = 1'b1;
      c++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_timeout: got no commit in 40 cycles, expected one (addr %h)", a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input int n);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Burn draws with harmless reads of 0x100 until the next draw is >= min.
  task automatic ensure_draw(input logic [4:0] min);
    int n;
    n = 0;
    while (peek_draw() < min && n < 64) begin
      do_req(1'b0, 1'b1, 32'h100, 32'h0);
      n++;
    end
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] ra;
  int          rk, rop;

  initial begin
    // Reset held with a read request pending: no stall, no data.
    rstn        = 1'b0;
    read_enable = 1'b1;
    addr        = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 32'h0);
    read_enable = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic write then read; first request uses the seed's draw.
    do_req(1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    do_req(1'b0, 1'b1, 32'h100, 32'h0);
    go_idle(2);

    // Byte aliasing: low two bits and bits above the word index are ignored.
    do_req(1'b1, 1'b0, 32'h104, 32'hCAFEF00D);
    do_req(1'b0, 1'b1, 32'h107, 32'h0);
    do_req(1'b0, 1'b1, 32'h104 + (32'h1 << (ADDR_W + 2)), 32'h0);

    // Both enables: write wins, data_out holds, then read back.
    do_req(1'b1, 1'b1, 32'h200, 32'h1234);
    do_req(1'b0, 1'b1, 32'h200, 32'h0);
    go_idle(1);

`ifdef MEMSIM_RANDOM_STALL_EN
    // Abort mid-WAIT on a write to a word holding 0.
    do_req(1'b1, 1'b0, 32'h300, 32'h0);
    ensure_draw(5'd2);
    model_step();
    write_enable = 1'b1;
    read_enable  = 1'b0;
    addr         = 32'h300;
    data_in      = 32'hBAD0BAD0;
    @(negedge clk);
    check("abort_miss_high", 32'(miss), 32'd1);
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    #1;
    check("abort_miss_low", 32'(miss), 32'd0);
    @(posedge clk);
    #1;
    do_req(1'b0, 1'b1, 32'h300, 32'h0);

    // Reset mid-WAIT on a write: nothing written, data_out and LFSR restart.
    ensure_draw(5'd2);
    write_enable = 1'b1;
    addr         = 32'h300;
    data_in      = 32'h5555AAAA;
    @(negedge clk);
    check("rstwait_miss_high", 32'(miss), 32'd1);
    #2;
    rstn         = 1'b0;
    write_enable = 1'b0;
    m_lfsr       = SEED;
    m_dout       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rstwait_data_out", data_out, 32'h0);
    do_req(1'b0, 1'b1, 32'h300, 32'h0);
    go_idle(1);
`endif

    // Randomised traffic over 16 preloaded words, back-to-back.
    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, 1'b0, 32'h1000 | (32'(i) << 2), $urandom);
    end
    for (int i = 0; i < 1000; i++) begin
      rk  = int'($urandom_range(0, 15));
      rop = int'($urandom_range(0, 2));
      ra  = 32'h1000 | (32'(rk) << 2) | 32'($urandom_range(0, 3))
          | (32'($urandom_range(0, 1)) << (ADDR_W + 2));
      do_req(rop != 1, rop != 0, ra, $urandom);
    end
    go_idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no end of test by 5 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
